// File: rtl/multi_sel_param.sv
// rtl/multi_sel_param.sv - constant-coefficient multiply sequencer, one product per beat
// Optional MULTI_SEL_REPEAT_EN: replay the held sample when a sequence ends with no new accept.
module multi_sel_param #(
  parameter int DW = 8,
  parameter int NCOEF = 4,
  parameter int CW = 4,
  parameter logic [NCOEF*CW-1:0] COEFS = {4'd8, 4'd7, 4'd3, 4'd1},
  parameter int OW = DW + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          input_grant,
  output logic [OW-1:0] out,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);
  localparam logic [CW-1:0] COEF0 = COEFS[CW-1:0];
  localparam logic SINGLE = (NCOEF == 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [DW-1:0] samp;
  logic [IW-1:0] idx_next;
  logic          accept;
  logic          advance;
  logic          seq_end;

  // Unsigned shift-and-add; OW is wide enough that nothing is ever truncated.
  function automatic logic [OW-1:0] mul(input logic [DW-1:0] a, input logic [CW-1:0] c);
    logic [OW-1:0] acc;
    acc = '0;
    for (int i = 0; i < CW; i++) begin
      if (c[i]) acc = acc + (OW'(a) << i);
    end
    return acc;
  endfunction

  function automatic logic [CW-1:0] coef_at(input logic [IW-1:0] i);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < NCOEF; k++) begin
      if (IW'(k) == i) c = COEFS[k*CW +: CW];
    end
    return c;
  endfunction

  assign in_ready = (state == IDLE) | (out_last & out_ready);
  assign accept   = in_valid & in_ready;
  assign advance  = (state == RUN) & out_ready & ~out_last;
  assign seq_end  = (state == RUN) & out_ready & out_last;
  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      samp        <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      input_grant <= 1'b0;
    end else begin
      input_grant <= 1'b0;
      if (accept) begin
        // A new sample takes priority over finishing or replaying the current one.
        state       <= RUN;
        samp        <= d;
        idx         <= '0;
        out         <= mul(d, COEF0);
        out_valid   <= 1'b1;
        out_last    <= SINGLE;
        input_grant <= 1'b1;
      end else if (advance) begin
        idx      <= idx_next;
        out      <= mul(samp, coef_at(idx_next));
        out_last <= (idx_next == LAST_IDX);
      end else if (seq_end) begin
`ifdef MULTI_SEL_REPEAT_EN
        idx      <= '0;
        out      <= mul(samp, COEF0);
        out_last <= SINGLE;
`else
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/multi_sel_param.md
# multi_sel_param

Parametrised constant-coefficient multiply sequencer, the successor to the fixed 8-bit multi_sel. For each accepted input sample it emits one product per beat, `sample × COEF[i]` for i = 0..NCOEF-1, on a registered output with valid/ready backpressure. It also has an explicit input handshake, and it can run back-to-back sequences with no bubble. It sits between an upstream sample source and downstream scaling/accumulation logic.

## Interface
Parameters:
- DW, 8: input sample width.
- NCOEF, 4: coefficients per sequence (≥1).
- CW, 4: coefficient width (≥1).
- COEFS, {4'd8,4'd7,4'd3,4'd1}: packed NCOEF×CW vector; COEF[i] = COEFS[i*CW +: CW]. The default is the sequence 1, 3, 7, 8.
- OW, DW+CW: output width (derived, do not override).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- d, input, DW: sample data.
- in_valid, input, 1: d is valid.
- in_ready, output, 1: block can accept d this cycle.
- input_grant, output, 1: one-cycle registered pulse marking the first beat of a newly accepted sample.
- out, output, OW: product, registered.
- out_valid, output, 1: out is valid.
- out_last, output, 1: current beat is COEF[NCOEF-1].
- out_ready, input, 1: downstream accepts out.

## Operation
- State: IDLE (out_valid=0) and RUN (out_valid=1). There is an index counter idx of width $clog2(NCOEF), minimum 1 bit, and a sample register samp (DW bits).
- Ready logic (combinational): in_ready = !out_valid | (out_last & out_ready).
- Accept (in_valid & in_ready) at an edge:
  - samp <= d, idx <= 0, out <= d×COEF[0].
  - out_valid <= 1, out_last <= (NCOEF==1), input_grant <= 1.
  - From IDLE or from the last beat, the state goes to RUN.
- Advance (out_valid & out_ready & !out_last):
  - idx <= idx+1, out <= samp×COEF[idx+1].
  - out_last <= (idx+1 == NCOEF-1), input_grant <= 0.
- Last beat taken (out_valid & out_ready & out_last) with no accept: handled by the configured end-of-sequence behaviour (see Configuration).
- Stall (out_valid & !out_ready): out, out_last, idx and samp hold; input_grant <= 0.
- input_grant is 0 on every cycle not preceded by an accept.
- Arithmetic:
  - Unsigned shift-and-add over CW coefficient bits; the result is zero-extended to OW.
  - There is no truncation: the maximum (2^DW−1)(2^CW−1) fits in OW.
  - A coefficient of 0 yields out=0 as a valid beat; no beat is skipped.
- d is sampled only on accept. Changes to d at other times have no effect on the sequence in flight.

## Timing
- Reset (rst=0, asynchronous): out=0, out_valid=0, out_last=0, input_grant=0, idx=0, samp=0. in_ready=1 while in reset.
- Latency: accept at edge k gives out=d×COEF[0] and input_grant=1 in cycle k..k+1.
- Throughput: one beat per cycle with out_ready=1. A sequence takes NCOEF cycles; back-to-back sequences have zero bubble.
- Simultaneous last-beat handoff and new accept: the new sample wins. The next beat is new d×COEF[0], input_grant=1.
- Reset deasserted mid-sequence: no partial resume; the block restarts from IDLE.
- idx never exceeds NCOEF-1; it is not required to wrap naturally.

## Configuration
- MULTI_SEL_REPEAT_EN.
- Defined: when the last beat is taken with no accept, the sequence restarts on the held samp.
  - idx <= 0, out <= samp×COEF[0], out_valid stays 1, input_grant <= 0.
  - The output therefore streams continuously after the first sample; a new d is taken only at sequence boundaries.
- Undefined: when the last beat is taken with no accept, out_valid <= 0 and out_last <= 0, and the block returns to IDLE. out holds its last value.

## Test plan
- Reset then single sample: d=143 with in_valid for one cycle and out_ready=1.
  - out = 143, 429, 1001, 1144 on consecutive cycles.
  - input_grant=1 only on the 143 beat; out_last only on 1144.
  - Then out_valid=0 (macro undefined).
- Full scale: d=255 gives out = 255, 765, 1785, 2040, with no overflow at OW=12.
- Backpressure: d=7 with out_ready toggled 1,0,0,1,1,1.
  - Beats 7, 21, 49, 56 are delivered in order.
  - Values hold during stalls; in_ready=0 until the last beat is taken.
- Back-to-back: d=6 then d=128 offered with in_valid held high.
  - Beats 6, 18, 42, 48, 128, 384, 896, 1024 with no gap.
  - input_grant pulses on the 6 and 128 beats.
- Reset mid-operation: assert rst low during the 429 beat of d=143.
  - All outputs go to 0 immediately.
  - After release with in_valid=0, out_valid stays 0.
- MULTI_SEL_REPEAT_EN build: one accept of d=129, then in_valid=0.
  - Output repeats 129, 387, 903, 1032 indefinitely.
  - input_grant pulses only once.
